// File: rtl/irq_ctrl.sv
// Prioritised, nestable interrupt controller with a bus-mapped register file.
// Channel 0 has the highest priority; only channels above the lowest in-service one may nest.

module irq_ctrl #(
    parameter int unsigned        NUM_IRQ       = 4,
    parameter int unsigned        SYNC_STAGES   = 2,
    parameter logic [15:0]        BASE_ADDR     = 16'h1100,
    parameter logic [15:0]        VECTOR_BASE   = 16'h0004,
    parameter logic [15:0]        VECTOR_STRIDE = 16'h0002,
    parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT  = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               gie,
    output logic               irq_req,
    output logic [15:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic [NUM_IRQ-1:0] irq_clr,
    input  logic [15:0]        bus_addr,
    input  logic [7:0]         bus_wdata,
    input  logic               bus_we,
    input  logic               bus_re,
    output logic [7:0]         bus_rdata
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic {StIdle, StReq} stateT;

    stateT              stateQ, stateD;
    logic [IdxW-1:0]    idxQ, idxD, winIdx;
    logic               reqQ, reqD;
    logic [15:0]        vecQ, vecD, vecCalc;
    logic [NUM_IRQ-1:0] clrQ;

    logic [NUM_IRQ-1:0] syncQ [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prevQ, syncLvl, rise;
    logic [NUM_IRQ-1:0] enableQ, edgeQ, pendQ, pendD, latchQ, latchD, inservQ, inservD;
    logic [NUM_IRQ-1:0] ackVec, allowed, cand, swSet, w1c, wrData, regVal;
    logic               blocked, candAny;

    logic [15:0] busOff;
    logic        busHit, wrEnable, wrEdge, unusedWdata;
    logic [2:0]  regSel;

    // Synchroniser chain plus one extra flop used for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) syncQ[s] <= '0;
            prevQ <= '0;
        end else begin
            syncQ[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) syncQ[s] <= syncQ[s-1];
            prevQ <= syncQ[SYNC_STAGES-1];
        end
    end

    assign syncLvl = syncQ[SYNC_STAGES-1];
    assign rise    = syncLvl & ~prevQ;

    assign busOff      = bus_addr - BASE_ADDR;
    assign busHit      = (busOff < 16'd5);
    assign regSel      = busOff[2:0];
    assign wrData      = bus_wdata[NUM_IRQ-1:0];
    assign unusedWdata = ^bus_wdata;
    assign wrEnable    = bus_we && busHit && (regSel == 3'd0);
    assign wrEdge      = bus_we && busHit && (regSel == 3'd2);
    assign w1c         = (bus_we && busHit && (regSel == 3'd1)) ? wrData : '0;
    assign swSet       = (bus_we && busHit && (regSel == 3'd4)) ? wrData : '0;

    always_comb begin
        ackVec = '0;
        if (stateQ == StReq && irq_ack) ackVec[idxQ] = 1'b1;
    end

    // Set terms are OR-ed in last so they win over W1C and ack.
    assign latchD  = ~edgeQ & ((latchQ & ~ackVec) | swSet);
    assign pendD   = (edgeQ & ((pendQ & ~(w1c | ackVec)) | rise | swSet))
                   | (~edgeQ & (syncLvl | latchD));
    assign inservD = (irq_eoi ? (inservQ & (inservQ - 1'b1)) : inservQ) | ackVec;

    always_comb begin
        blocked = 1'b0;
        allowed = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (inservQ[i]) blocked = 1'b1;
            allowed[i] = ~blocked;
        end
        cand    = pendQ & enableQ & allowed;
        candAny = |cand;
        winIdx  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) winIdx = IdxW'(i);
        end
        vecCalc = VECTOR_BASE + VECTOR_STRIDE * 16'(winIdx);
    end

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        reqD   = reqQ;
        vecD   = vecQ;
        unique case (stateQ)
            StIdle: begin
                if (gie && candAny) begin
                    idxD   = winIdx;
                    vecD   = vecCalc;
                    reqD   = 1'b1;
                    stateD = StReq;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    reqD   = 1'b0;
                    stateD = StIdle;
                end else if (!enableQ[idxQ] || !pendQ[idxQ]) begin
                    reqD   = 1'b0;
                    stateD = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= StIdle;
            idxQ    <= '0;
            reqQ    <= 1'b0;
            vecQ    <= '0;
            clrQ    <= '0;
            enableQ <= '0;
            edgeQ   <= EDGE_DEFAULT;
            pendQ   <= '0;
            latchQ  <= '0;
            inservQ <= '0;
        end else begin
            stateQ  <= stateD;
            idxQ    <= idxD;
            reqQ    <= reqD;
            vecQ    <= vecD;
            clrQ    <= ackVec;
            pendQ   <= pendD;
            latchQ  <= latchD;
            inservQ <= inservD;
            if (wrEnable) enableQ <= wrData;
            if (wrEdge)   edgeQ   <= wrData;
        end
    end

    assign irq_req    = reqQ;
    assign irq_vector = vecQ;
    assign irq_clr    = clrQ;

    always_comb begin
        regVal    = '0;
        bus_rdata = '0;
        if (bus_re && busHit) begin
            case (regSel)
                3'd0:    regVal = enableQ;
                3'd1:    regVal = pendQ;
                3'd2:    regVal = edgeQ;
                3'd3:    regVal = inservQ;
                default: regVal = '0;
            endcase
        end
        bus_rdata[NUM_IRQ-1:0] = regVal;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl against a priority-order reference model.

module tb_irq_ctrl;

    localparam int unsigned N    = 4;
    localparam logic [15:0] BASE = 16'h1100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in;
    logic         gie;
    logic         irq_req;
    logic [15:0]  irq_vector;
    logic         irq_ack;
    logic         irq_eoi;
    logic [N-1:0] irq_clr;
    logic [15:0]  bus_addr;
    logic [7:0]   bus_wdata;
    logic         bus_we;
    logic         bus_re;
    logic [7:0]   bus_rdata;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(
        .NUM_IRQ      (N),
        .SYNC_STAGES  (2),
        .BASE_ADDR    (BASE),
        .VECTOR_BASE  (16'h0004),
        .VECTOR_STRIDE(16'h0002),
        .EDGE_DEFAULT (4'hF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .gie       (gie),
        .irq_req   (irq_req),
        .irq_vector(irq_vector),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi),
        .irq_clr   (irq_clr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic busWrite(input logic [2:0] off, input logic [7:0] data);
        bus_addr  = BASE + 16'(off);
        bus_wdata = data;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
        bus_addr  = 16'h0000;
    endtask

    task automatic chkReg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        bus_addr = BASE + 16'(off);
        bus_re   = 1'b1;
        #1;
        d        = bus_rdata;
        bus_re   = 1'b0;
        bus_addr = 16'h0000;
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    task automatic ackIt();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic eoiIt();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    // Bounded wait; an expired budget is reported as a failed comparison.
    task automatic waitReq(input string tag, input int maxC);
        int n = 0;
        while (!irq_req && n < maxC) begin
            tick();
            n++;
        end
        chk(tag, 32'(irq_req), 32'd1);
    endtask

    function automatic int lowestBit(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; irq_in = '0; gie = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
        #12;
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_vec", 32'(irq_vector), 32'd0);
        chk("rst_clr", 32'(irq_clr), 32'd0);
        chkReg("rst_enable", 3'd0, 8'h00);
        chkReg("rst_pending", 3'd1, 8'h00);
        chkReg("rst_edge", 3'd2, 8'h0F);
        chkReg("rst_inserv", 3'd3, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single edge channel: latency, vector, ack bookkeeping.
        gie = 1'b1;
        busWrite(3'd0, 8'h03);
        pulse(4'b0010);
        tick(2);
        chk("t1_early", 32'(irq_req), 32'd0);
        chkReg("t1_pend_set", 3'd1, 8'h02);
        tick();
        chk("t1_req", 32'(irq_req), 32'd1);
        chk("t1_vec", 32'(irq_vector), 32'h0006);
        ackIt();
        chk("t1_clr", 32'(irq_clr), 32'h2);
        chk("t1_req_drop", 32'(irq_req), 32'd0);
        chkReg("t1_inserv", 3'd3, 8'h02);
        chkReg("t1_pend_clr", 3'd1, 8'h00);
        tick();
        chk("t1_clr_once", 32'(irq_clr), 32'h0);
        eoiIt();
        chkReg("t1_eoi", 3'd3, 8'h00);
        chk("bus_unsel", 32'(bus_rdata), 32'd0);

        // Simultaneous arrival resolves by priority.
        busWrite(3'd0, 8'h0F);
        pulse(4'b0101);
        waitReq("t2_req0", 10);
        chk("t2_vec0", 32'(irq_vector), 32'h0004);
        ackIt();
        tick(2);
        chk("t2_blocked", 32'(irq_req), 32'd0);
        eoiIt();
        waitReq("t2_req2", 10);
        chk("t2_vec2", 32'(irq_vector), 32'h0008);
        ackIt();
        eoiIt();

        // Nesting: only channels above the in-service one may interrupt.
        pulse(4'b0100);
        waitReq("t3_req2", 10);
        chk("t3_vec2", 32'(irq_vector), 32'h0008);
        ackIt();
        pulse(4'b1000);
        tick(6);
        chk("t3_no_nest3", 32'(irq_req), 32'd0);
        chkReg("t3_pend3", 3'd1, 8'h08);
        pulse(4'b0001);
        waitReq("t3_req0", 10);
        chk("t3_vec0", 32'(irq_vector), 32'h0004);
        ackIt();
        chkReg("t3_inserv05", 3'd3, 8'h05);
        eoiIt();
        chkReg("t3_inserv04", 3'd3, 8'h04);
        eoiIt();
        waitReq("t3_req3", 10);
        chk("t3_vec3", 32'(irq_vector), 32'h000A);
        ackIt();
        eoiIt();

        // Withdrawal when the channel is disabled while requesting.
        pulse(4'b0010);
        waitReq("t4_req", 10);
        busWrite(3'd0, 8'h00);
        tick();
        chk("t4_withdraw", 32'(irq_req), 32'd0);
        chk("t4_no_clr", 32'(irq_clr), 32'h0);
        chkReg("t4_pend_kept", 3'd1, 8'h02);
        busWrite(3'd1, 8'h02);
        chkReg("t4_w1c", 3'd1, 8'h00);
        busWrite(3'd0, 8'h0F);

        // Level channel and software trigger.
        busWrite(3'd2, 8'h0E);
        irq_in = 4'b0001;
        waitReq("t5_req", 10);
        chk("t5_vec", 32'(irq_vector), 32'h0004);
        ackIt();
        chk("t5_clr", 32'(irq_clr), 32'h1);
        chkReg("t5_pend_level", 3'd1, 8'h01);
        eoiIt();
        waitReq("t5_reassert", 10);
        irq_in = 4'b0000;
        tick(5);
        chk("t5_drop", 32'(irq_req), 32'd0);
        chkReg("t5_pend_gone", 3'd1, 8'h00);
        busWrite(3'd4, 8'h01);
        waitReq("t5_sw_req", 5);
        chk("t5_sw_vec", 32'(irq_vector), 32'h0004);
        ackIt();
        chk("t5_sw_clr", 32'(irq_clr), 32'h1);
        chkReg("t5_sw_pend", 3'd1, 8'h00);
        eoiIt();
        tick(3);
        chk("t5_sw_once", 32'(irq_req), 32'd0);
        chkReg("t5_swtrig_rd", 3'd4, 8'h00);
        busWrite(3'd2, 8'h0F);

        // W1C in the same cycle as a new edge: the edge wins.
        busWrite(3'd0, 8'h00);
        pulse(4'b0100);
        tick();
        busWrite(3'd1, 8'h04);
        chkReg("t6_set_wins", 3'd1, 8'h04);
        busWrite(3'd1, 8'h04);
        chkReg("t6_w1c", 3'd1, 8'h00);

        // Asynchronous reset while requesting.
        busWrite(3'd0, 8'h04);
        pulse(4'b0100);
        waitReq("t7_req", 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_req_async", 32'(irq_req), 32'd0);
        chk("t7_vec", 32'(irq_vector), 32'd0);
        chkReg("t7_enable", 3'd0, 8'h00);
        chkReg("t7_pending", 3'd1, 8'h00);
        chkReg("t7_edge", 3'd2, 8'h0F);
        rst_n = 1'b1;
        tick();

        // Random masks: requests must be served in ascending channel order.
        for (int it = 0; it < 16; it++) begin
            logic [N-1:0] en, msk, left;
            int k;
            en  = N'($urandom_range(15, 1));
            msk = N'($urandom_range(15, 1));
            gie = 1'b0;
            busWrite(3'd0, 8'(en));
            pulse(msk);
            tick(4);
            chkReg("rnd_pend", 3'd1, 8'(msk));
            gie  = 1'b1;
            left = en & msk;
            while (left != '0) begin
                k = lowestBit(left);
                waitReq("rnd_req", 12);
                chk("rnd_vec", 32'(irq_vector), 32'(16'h0004 + 16'(2 * k)));
                ackIt();
                chk("rnd_clr", 32'(irq_clr), 32'(1) << k);
                eoiIt();
                left[k] = 1'b0;
            end
            tick(3);
            chk("rnd_idle", 32'(irq_req), 32'd0);
            chkReg("rnd_left", 3'd1, 8'(msk & ~en));
            busWrite(3'd1, 8'h0F);
            gie = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Parametrised interrupt controller that replaces the CPU's single interrupt_0/interrupt_0_clr pair with NUM_IRQ prioritised channels.
- Sits between peripheral interrupt lines and the CPU control unit.
- Synchronises and latches requests, picks the highest-priority eligible channel and presents a vector.
- Tracks in-service channels so that only higher-priority interrupts can nest.
- Configured through the data memory/IO bus.

Parameters:
NUM_IRQ, 4, channel count, 1..8; channel 0 has the highest priority.
SYNC_STAGES, 2, synchroniser flops per irq_in line, minimum 2.
BASE_ADDR, 16'h1100, bus address of register 0.
VECTOR_BASE, 16'h0004, vector for channel 0.
VECTOR_STRIDE, 16'h0002, vector spacing between channels.
EDGE_DEFAULT, all ones, reset value of the EDGE register.

Ports:
clk  in  1  system clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
irq_in  in  NUM_IRQ  raw peripheral interrupt lines, asynchronous.
gie  in  1  global interrupt enable (CPU status bit 3).
irq_req  out  1  request to the CPU control unit.
irq_vector  out  16  handler address; valid while irq_req=1.
irq_ack  in  1  one-cycle pulse: CPU has taken the request.
irq_eoi  in  1  one-cycle pulse: handler return (reti).
irq_clr  out  NUM_IRQ  one-cycle clear pulse back to the acknowledged peripheral.
bus_addr  in  16  data/IO address.
bus_wdata  in  8  write data.
bus_we  in  1  write strobe.
bus_re  in  1  read strobe.
bus_rdata  out  8  read data; 0 when not selected.

Behaviour:
Reset (asynchronous):
- ENABLE=0, PENDING=0, INSERV=0, EDGE=EDGE_DEFAULT, synchronisers=0, state=IDLE.
- irq_req=0, irq_vector=0, irq_clr=0.

Registers (offset from BASE_ADDR; bits at or above NUM_IRQ read 0 and ignore writes):
- 0 ENABLE: read/write mask.
- 1 PENDING: read; write 1 to clear, edge channels only.
- 2 EDGE: read/write; 1=rising-edge channel, 0=level channel.
- 3 INSERV: read-only.
- 4 SWTRIG: write 1 sets PENDING; reads 0.
- Reads are combinational, same cycle as bus_re. Writes take effect at the next clock edge.

Pending:
- Edge channel: set on a synchronised 0->1 transition or SWTRIG. Cleared by W1C or by ack of that channel.
- Level channel: PENDING = synchronised level OR a SWTRIG latch. The latch is cleared by ack.
- Set beats clear on the same channel in the same cycle: edge or SWTRIG versus W1C or ack.
- Input to PENDING latency: SYNC_STAGES+1 cycles.

Eligibility:
- cand = PENDING & ENABLE.
- winner = lowest index i with cand[i]=1 and i below the lowest set INSERV bit (or any i when INSERV=0).

State machine:
- IDLE: if gie=1 and a winner exists, latch idx and go to REQ. irq_req=1 and irq_vector=VECTOR_BASE+idx*VECTOR_STRIDE (16-bit wrap) are registered, one cycle after the winner is seen.
- REQ: idx and irq_vector are held stable even if a higher-priority channel arrives.
  - irq_ack: set INSERV[idx], clear PENDING[idx] per the pending rules, pulse irq_clr[idx] for exactly one cycle, drop irq_req the next cycle, go to IDLE.
  - ENABLE[idx] cleared, or PENDING[idx] lost (level line dropped or W1C) with no ack this cycle: withdraw. irq_req drops next cycle, go to IDLE, no irq_clr pulse.
  - gie changes are ignored in REQ.
- EOI: clears the lowest set INSERV bit. It is ignored when INSERV=0. It is legal in any state.
- EOI and ack in the same cycle: EOI clears first, then ack sets INSERV[idx].
- irq_ack while in IDLE: ignored.
- Reset mid-REQ: irq_req drops immediately and all state returns to reset values.

Test Plan:
- Reset, ENABLE=4'b0011, gie=1, pulse irq_in[1] high for 1 cycle -> irq_req=1 at cycle SYNC_STAGES+2 with vector 16'h0006. Ack -> irq_clr=4'b0010 for 1 cycle, INSERV reads 8'h02, PENDING reads 8'h00.
- irq_in[2] and irq_in[0] rise in the same cycle, ENABLE=4'hF -> vector 16'h0004 first. Ack, then EOI -> vector 16'h0008 follows.
- Nesting: channel 2 in service, irq_in[3] rises -> no irq_req. irq_in[0] rises -> irq_req with vector 16'h0004. After ack, INSERV=8'h05. EOI -> INSERV=8'h04.
- Withdrawal: in REQ for channel 1, write ENABLE=0 -> irq_req=0 next cycle, irq_clr stays 0, PENDING[1] still 1.
- Level channel (EDGE[0]=0): hold irq_in[0]=1 and ack -> request reappears after IDLE. Release the input -> PENDING[0]=0, no request. Write SWTRIG=8'h01 -> one request; after its ack, PENDING[0]=0.
- Same-cycle collisions: W1C of PENDING[2] in the cycle a new edge arrives -> PENDING[2] stays 1. Drive rst_n low while in REQ -> irq_req=0 asynchronously and all registers return to reset values.
